// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_t : FSM state encoding, also driven out on the STATE debug port
//   STATE_W : width of the state encoding
package fsm_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
//   gclk, grst_n : clock, asynchronous active-low reset
//   inc          : count one event this cycle
//   clr          : synchronous clear; an inc in the same cycle still counts
//   cnt          : current count, holds at all-ones
//   ovf          : set when an event arrives while cnt is all-ones; cleared only by clr/reset
module sat_counter #(
    parameter int W = 8
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // clear first, then count the coincident event
            cnt <= W'(inc);
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) ovf <= 1'b1;
            else      cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
//   CLK, RST             : clock, asynchronous active-low reset
//   EN                   : detector enable; dropping it returns the FSM to IDLE and flushes the window
//   DATA, DATA_VALID     : serial bit and its qualifier (sampled only when EN=1 too)
//   OVERLAP              : 1 keeps the window after a match, 0 restarts it
//   PAT_LOAD, PAT_IN     : pattern load, honoured only while in IDLE; PAT_IN MSB is the first bit
//   CNT_CLR              : synchronous clear of MATCH_CNT / CNT_OVF
//   DETECT               : registered one-cycle match pulse
//   MATCH_CNT, CNT_OVF   : saturating match count and sticky overflow
//   STATE                : current FSM state (debug)
module seq_detector_param
    import fsm_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               DATA,
    input  logic               DATA_VALID,
    input  logic               OVERLAP,
    input  logic               PAT_LOAD,
    input  logic [PAT_W-1:0]   PAT_IN,
    input  logic               CNT_CLR,
    output logic               DETECT,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               CNT_OVF,
    output logic [STATE_W-1:0] STATE
);

    localparam int               FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  sr_q;     // only PAT_W-1 history bits are needed; the newest comes from DATA
    logic [FILL_W-1:0] fill_q, fill_d;
    state_t            state_q, state_d;
    logic              accept, match;
    logic [PAT_W-1:0]  window;

    assign accept = EN & DATA_VALID;
    assign window = {sr_q, DATA};
    assign match  = accept && (fill_q >= FILL_W'(PAT_W - 1)) && (window == pat_q);

    always_comb begin
        fill_d = fill_q;
        if (!EN) begin
            fill_d = '0;
        end else if (accept) begin
            // non-overlap: the next match must be built from PAT_W fresh bits
            if (match && !OVERLAP) fill_d = '0;
            else if (fill_q != FULL) fill_d = fill_q + FILL_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!EN)                   state_d = IDLE;
        else if (accept)           state_d = (fill_d == FULL) ? HUNT : FILL;
        else if (state_q == IDLE)  state_d = FILL;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pat_q   <= DEFAULT_PAT;
            sr_q    <= '0;
            fill_q  <= '0;
            state_q <= IDLE;
            DETECT  <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            DETECT  <= match;
            if (!EN)         sr_q <= '0;
            else if (accept) sr_q <= window[PAT_W-2:0];
            if (PAT_LOAD && state_q == IDLE) pat_q <= PAT_IN;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .gclk   (CLK),
        .grst_n (RST),
        .inc    (match),
        .clr    (CNT_CLR),
        .cnt    (MATCH_CNT),
        .ovf    (CNT_OVF)
    );

    assign STATE = state_q;

endmodule
